seq_restoring_divider: RTL and testbench

//  Sequential unsigned restoring divider: the inverse of the multiplier datapath.

---
 rtl/seq_restoring_divider_pkg.sv | 13 +
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider_div_step.sv | 23 ++
 rtl/seq_restoring_divider.sv | 129 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_restoring_divider_pkg;

  // Default divisor/remainder width; dividend and quotient are twice this.
  localparam int unsigned DefaultN = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus for the divider.
interface seq_restoring_divider_if #(
  parameter int unsigned N = 5
) ();

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division stage: shift in the next dividend bit, subtract if it fits.
module seq_restoring_divider_div_step #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] rem_next_o,
  output logic         qbit_o
);

  logic [N:0]   p;
  logic [N-1:0] diff;

  // Conditional subtract; the difference always fits in N bits when taken since it is < divisor.
  always_comb begin
    p          = {rem_i, dvd_msb_i};
    diff       = p[N-1:0] - divisor_i;
    qbit_o     = (p >= {1'b0, divisor_i});
    rem_next_o = qbit_o ? diff : p[N-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit
// per clock, with a start/busy/done handshake.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input logic                   clock,
  input logic                   reset,
  seq_restoring_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(2 * N);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * N - 1);

  div_state_e     st_q, st_d;
  logic [2*N-1:0] dvd_q, dvd_d;    // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [N-1:0]   dsr_q, dsr_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] quot_q, quot_d;
  logic [N-1:0]   remo_q, remo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   step_rem;
  logic           step_qbit;

  seq_restoring_divider_div_step #(
    .N (N)
  ) u_div_step (
    .rem_i      (rem_q),
    .dvd_msb_i  (dvd_q[2*N-1]),
    .divisor_i  (dsr_q),
    .rem_next_o (step_rem),
    .qbit_o     (step_qbit)
  );

  // Next-state logic for FSM, datapath and registered outputs.
  always_comb begin
    st_d   = st_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    remo_d = remo_q;
    busy_d = busy_q;
    done_d = done_q;
    dbz_d  = dbz_q;
    unique case (st_q)
      StIdle: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dsr_d = bus.divisor;
          rem_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            st_d   = StDone;
            quot_d = '1;
            remo_d = '0;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            st_d   = StRun;
            busy_d = 1'b1;
          end
        end
      end
      StRun: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[2*N-2:0], step_qbit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          st_d   = StDone;
          quot_d = {dvd_q[2*N-2:0], step_qbit};
          remo_d = step_rem;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      StDone: begin
        st_d   = StIdle;
        done_d = 1'b0;
      end
      default: begin
        st_d   = StIdle;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset dominates start.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= StIdle;
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for the sequential restoring divider (N=5).
module tb_seq_restoring_divider;

  localparam int unsigned N = 5;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  seq_restoring_divider_if #(.N(N)) bus ();

  seq_restoring_divider #(
    .N (N)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drive a one-cycle start at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2*N-1:0] dvd, input logic [N-1:0] dsr);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
  endtask

  // Bounded wait for done; cyc counts negedges waited, overlap flags busy&done together.
  task automatic wait_done(output int cyc, output bit overlap);
    cyc     = 0;
    overlap = 1'b0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.dividend = 10'd36;
    bus.divisor  = 5'd2;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit ov;
    issue(10'd36, 5'd2);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b done=%b want 1/0", bus.busy, bus.done);
    end
    wait_done(cyc, ov);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles want 10", cyc);
    end
    checks++;
    if (ov !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done_overlap: got overlap=%b busy=%b want 0/0", ov, bus.busy);
    end
    checks++;
    if (bus.quotient !== 10'd18 || bus.remainder !== 5'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want 18/0/0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 10'd18) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b q=%0d want 0/18", bus.done, bus.quotient);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.quotient !== 10'd18 || bus.remainder !== 5'd0) begin
      errors++;
      $display("FAIL basic_hold: got q=%0d r=%0d want 18/0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ov;
    issue(10'd54, 5'd18);
    wait_done(cyc, ov);
    checks++;
    if (cyc !== 10 || bus.quotient !== 10'd3 || bus.remainder !== 5'd0) begin
      errors++;
      $display("FAIL b2b_first: got cyc=%0d q=%0d r=%0d want 10/3/0",
               cyc, bus.quotient, bus.remainder);
    end
    issue(10'd100, 5'd7);
    checks++;
    if (bus.busy !== 1'b1 || bus.quotient !== 10'd3) begin
      errors++;
      $display("FAIL b2b_old_result_held: got busy=%b q=%0d want 1/3", bus.busy, bus.quotient);
    end
    wait_done(cyc, ov);
    checks++;
    if (cyc !== 10 || bus.quotient !== 10'd14 || bus.remainder !== 5'd2) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d q=%0d r=%0d want 10/14/2",
               cyc, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_extremes();
    int cyc;
    bit ov;
    issue(10'd1023, 5'd1);
    wait_done(cyc, ov);
    checks++;
    if (bus.quotient !== 10'd1023 || bus.remainder !== 5'd0) begin
      errors++;
      $display("FAIL max_div1: got q=%0d r=%0d want 1023/0", bus.quotient, bus.remainder);
    end
    issue(10'd1023, 5'd31);
    wait_done(cyc, ov);
    checks++;
    if (bus.quotient !== 10'd33 || bus.remainder !== 5'd0) begin
      errors++;
      $display("FAIL max_div31: got q=%0d r=%0d want 33/0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_div_by_zero();
    int cyc;
    bit ov;
    issue(10'd37, 5'd0);
    wait_done(cyc, ov);
    checks++;
    if (cyc !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_latency: got cyc=%0d busy=%b want 0/0", cyc, bus.busy);
    end
    checks++;
    if (bus.quotient !== 10'd1023 || bus.remainder !== 5'd0 || bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want 1023/0/1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_pulse: got done=%b dbz=%b want 0/1", bus.done, bus.div_by_zero);
    end
    issue(10'd9, 5'd4);
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear_on_accept: got dbz=%b want 0", bus.div_by_zero);
    end
    wait_done(cyc, ov);
    checks++;
    if (bus.quotient !== 10'd2 || bus.remainder !== 5'd1 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_next_op: got q=%0d r=%0d dbz=%b want 2/1/0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit ov;
    issue(10'd500, 5'd3);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 10'd10;
    bus.divisor  = 5'd5;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(cyc, ov);
    checks++;
    if (cyc !== 6 || bus.quotient !== 10'd166 || bus.remainder !== 5'd2) begin
      errors++;
      $display("FAIL start_ignored: got cyc=%0d q=%0d r=%0d want 6/166/2",
               cyc, bus.quotient, bus.remainder);
    end
    // A start held through DONE must not be taken either.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit ov;
    issue(10'd500, 5'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run_idle: got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    issue(10'd36, 5'd2);
    wait_done(cyc, ov);
    checks++;
    if (cyc !== 10 || bus.quotient !== 10'd18 || bus.remainder !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_run_after: got cyc=%0d q=%0d r=%0d want 10/18/0",
               cyc, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_sweep();
    int cyc;
    bit ov;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    for (int i = 0; i < 24; i++) begin
      a = 10'($urandom_range(0, 1023));
      b = 5'($urandom_range(1, 31));
      issue(a, b);
      wait_done(cyc, ov);
      checks++;
      if (cyc !== 10 || ov !== 1'b0 ||
          (20'(bus.quotient) * 20'(b) + 20'(bus.remainder)) !== 20'(a) ||
          bus.remainder >= b || bus.quotient !== a / 10'(b)) begin
        errors++;
        $display("FAIL sweep_%0d: %0d/%0d got q=%0d r=%0d cyc=%0d want q=%0d r=%0d cyc=10",
                 i, a, b, bus.quotient, bus.remainder, cyc, a / 10'(b), a % 10'(b));
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
